dma_chain: RTL and testbench

Descriptor queue and sequencer for the DRAM DMA engine. The Z80 writes complete 9-byte transfer descriptors into a small on-chip queue. The block then replays each descriptor into the DMA engine's register strobes and data bus, launches it, waits for completion, and starts the next one. This chains several DMA bursts without CPU intervention. Its strobe and data outputs are ORed and muxed with the Z80's own DMA port decode outside this block.

---
 rtl/dma_chain.sv | 171 +++++++++++++++++
 tb/tb_dma_chain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chain.sv
// dma_chain: descriptor queue and sequencer for the DRAM DMA engine.
// The Z80 streams 9-byte descriptors in via cmd_wr. Each complete descriptor is
// queued, then replayed one byte per cycle onto the DMA engine's register strobes,
// launched, and waited on before the next one starts.
module dma_chain #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_wr,
  input  logic [7:0]             cmd_data,
  input  logic                   abort,
  input  logic                   hold,
  input  logic                   ovf_clr,
  input  logic                   dma_act,
  output logic [8:0]             dmaport_wr,
  output logic [7:0]             dma_zdata,
  output logic                   seq_own,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   full,
  output logic                   ovf,
  output logic                   desc_done,
  output logic                   chain_int
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACT, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [1:0]      wait_q;
  logic [3:0]      byte_idx;
  logic [7:0][7:0] asm_q;
  logic [8:0][7:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt_d;
  logic            commit, push, pop, done;

  // Launch (ctrl, byte 8) goes last on bit 7; num (byte 7) uses bit 8.
  function automatic logic [8:0] strobe_of(input logic [3:0] k);
    case (k)
      4'd7:    strobe_of = 9'h100;
      4'd8:    strobe_of = 9'h080;
      default: strobe_of = 9'd1 << k;
    endcase
  endfunction

  assign commit  = cmd_wr && !abort && (byte_idx == 4'd8);
  assign push    = commit && !full;
  assign pop     = (state_q == LOAD) && (k_q == 4'd8) && !abort;
  assign done    = (state_q == WAIT_DONE) && !dma_act;

  assign full    = (fifo_cnt == CNT_FULL);
  assign busy    = (state_q != IDLE) || (fifo_cnt != '0);
  assign seq_own = (state_q == LOAD);

  // Queue occupancy after this cycle's abort/push/pop.
  always_comb begin
    cnt_d = fifo_cnt;
    if (abort)
      cnt_d = '0;
    else if (push && !pop)
      cnt_d = fifo_cnt + CW'(1);
    else if (pop && !push)
      cnt_d = fifo_cnt - CW'(1);
  end

  // Byte assembly, queue pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      fifo_cnt <= cnt_d;
      if (abort) begin
        byte_idx <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (cmd_wr) begin
          if (byte_idx == 4'd8) begin
            byte_idx <= '0;
          end else begin
            asm_q[byte_idx[2:0]] <= cmd_data;
            byte_idx             <= byte_idx + 4'd1;
          end
        end
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
      if (commit && full)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // Descriptor storage; the 9th byte is written straight from cmd_data.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_data, asm_q};
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if ((fifo_cnt != '0) && !dma_act && !hold && !abort) begin
          state_d = LOAD;
          k_d     = '0;
        end
      end
      LOAD: begin
        if (abort)
          state_d = IDLE;
        else if (k_q == 4'd8)
          state_d = WAIT_ACT;
        else
          k_d = k_q + 4'd1;
      end
      WAIT_ACT: begin
        if (dma_act || (wait_q == 2'd2))
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!dma_act)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered engine-side outputs. Strobes are computed from
  // the next state so each one lines up with the LOAD cycle that seq_own marks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      wait_q     <= '0;
      dmaport_wr <= '0;
      dma_zdata  <= '0;
      desc_done  <= 1'b0;
      chain_int  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wait_q     <= (state_q == WAIT_ACT) ? wait_q + 2'd1 : '0;
      dmaport_wr <= '0;
      dma_zdata  <= '0;
      if (state_d == LOAD) begin
        dmaport_wr <= strobe_of(k_d);
        dma_zdata  <= mem[rd_ptr][k_d];
      end
      desc_done  <= done;
      chain_int  <= done && (cnt_d == '0);
    end
  end

endmodule

// File: tb/tb_dma_chain.sv
// tb_dma_chain: randomized descriptors checked against a queue model of the
// descriptor FIFO plus a simple DMA-engine model that holds dma_act after launch.
module tb_dma_chain;

  localparam int DEPTH = 4;

  typedef logic [8:0][7:0] desc_t;
  typedef struct {
    logic [8:0] wr;
    logic [7:0] d;
    int         cyc;
  } strobe_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       cmd_wr   = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       abort    = 1'b0;
  logic       hold     = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic       dma_act  = 1'b0;
  logic [8:0] dmaport_wr;
  logic [7:0] dma_zdata;
  logic       seq_own, busy, full, ovf, desc_done, chain_int;
  logic [$clog2(DEPTH):0] fifo_cnt;

  dma_chain #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .abort(abort), .hold(hold), .ovf_clr(ovf_clr), .dma_act(dma_act),
    .dmaport_wr(dmaport_wr), .dma_zdata(dma_zdata), .seq_own(seq_own),
    .busy(busy), .fifo_cnt(fifo_cnt), .full(full), .ovf(ovf),
    .desc_done(desc_done), .chain_int(chain_int)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, act_len = 0, act_cnt = 0;
  int dd_cnt = 0, ci_cnt = 0, onehot_bad = 0, early_start = 0;
  int launch_cnt = -1, post_launch_cnt = -1;
  logic launched_prev = 1'b0;
  int rd_i = 0;
  strobe_t log_q[$];
  desc_t   mq[$];
  logic    mov = 1'b0;

  // Register bit receiving byte k: len->6, num->8, ctrl(launch)->7.
  int unsigned bitpos [9] = '{0, 1, 2, 3, 4, 5, 6, 8, 7};

  // Strobe logger, pulse counters and DMA engine model (dma_act held act_len cycles).
  always @(negedge clk) begin
    cyc++;
    if (dmaport_wr != '0) begin
      log_q.push_back('{dmaport_wr, dma_zdata, cyc});
      if (!$onehot(dmaport_wr)) onehot_bad++;
      if (dmaport_wr[0] && dma_act) early_start++;
    end
    if (desc_done) dd_cnt++;
    if (chain_int) ci_cnt++;
    if (launched_prev) post_launch_cnt = int'(fifo_cnt);
    if (dmaport_wr[7]) launch_cnt = int'(fifo_cnt);
    launched_prev = dmaport_wr[7];
    if (dmaport_wr[7]) act_cnt = act_len;
    else if (act_cnt > 0) act_cnt--;
    dma_act = (act_cnt != 0);
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    for (int i = 0; i < 9; i++) d[i] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  function automatic void model_push(input desc_t d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else mov = 1'b1;
  endfunction

  task automatic send_desc(input desc_t d);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmd_wr   = 1'b1;
      cmd_data = d[i];
    end
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || dma_act) && n < budget);
    check({tag, " idle"}, busy || dma_act, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_strobe(input string tag, input int b, input int budget);
    int n = 0;
    while (!dmaport_wr[b] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " strobe_seen"}, dmaport_wr[b], 1);
  endtask

  task automatic compare_desc(input string tag, input desc_t d, input int n);
    int prev = 0;
    for (int k = 0; k < n; k++) begin
      if (rd_i >= log_q.size()) begin
        check({tag, " missing"}, 0, 1);
        return;
      end
      check(tag, {log_q[rd_i].wr, log_q[rd_i].d}, {9'(1) << bitpos[k], d[k]});
      if (k > 0) check({tag, " gap"}, log_q[rd_i].cyc - prev, 1);
      prev = log_q[rd_i].cyc;
      rd_i++;
    end
  endtask

  task automatic drain_and_compare(input string tag);
    desc_t d;
    while (mq.size() > 0) begin
      d = mq.pop_front();
      compare_desc(tag, d, 9);
    end
    check({tag, " extra"}, log_q.size() - rd_i, 0);
  endtask

  task automatic run_batch(input string tag, input int n, input int alen);
    int dd0 = dd_cnt;
    int ci0 = ci_cnt;
    int acc;
    desc_t d;
    hold = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = rand_desc();
      model_push(d);
      send_desc(d);
    end
    acc = mq.size();
    check({tag, " cnt"}, fifo_cnt, acc);
    check({tag, " full"}, full, acc == DEPTH);
    check({tag, " ovf"}, ovf, mov);
    act_len = alen;
    hold = 1'b0;
    wait_idle(tag, 3000);
    drain_and_compare(tag);
    check({tag, " done_pulses"}, dd_cnt - dd0, acc);
    check({tag, " int_pulses"}, ci_cnt - ci0, 1);
    check({tag, " cnt_end"}, fifo_cnt, 0);
    check({tag, " ovf_sticky"}, ovf, mov);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check({tag, " ovf_clr"}, ovf, 0);
    mov = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t d;
    int dd0, ci0, base;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", {dmaport_wr, dma_zdata, seq_own, busy, fifo_cnt, full, ovf,
                       desc_done, chain_int}, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {dmaport_wr, dma_zdata, seq_own, busy, fifo_cnt, full, ovf,
                            desc_done, chain_int}, '0);

    // Single fixed descriptor, engine busy 50 cycles
    act_len = 50;
    d = {8'h81, 8'h00, 8'h0F, 8'h02, 8'h40, 8'h30, 8'h01, 8'h20, 8'h10};
    dd0 = dd_cnt; ci0 = ci_cnt;
    model_push(d);
    send_desc(d);
    check("single cnt", fifo_cnt, 1);
    wait_idle("single", 400);
    drain_and_compare("single");
    check("single launch_cnt", launch_cnt, 1);
    check("single post_launch_cnt", post_launch_cnt, 0);
    check("single done_pulses", dd_cnt - dd0, 1);
    check("single int_pulses", ci_cnt - ci0, 1);

    // Chain of 3 with fastest engine: launch to next first strobe is 4 cycles
    base = rd_i;
    run_batch("chain", 3, 2);
    if (log_q.size() > base + 9)
      check("chain min_gap", log_q[base + 9].cyc - log_q[base + 8].cyc, 4);
    else
      check("chain min_gap missing", 0, 1);

    // Overflow: 5 descriptors into a 4-deep queue while held
    run_batch("overflow", 5, 3);

    // Abort during LOAD at k = 4
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = rand_desc();
      model_push(d);
      send_desc(d);
    end
    act_len = 5;
    dd0 = dd_cnt;
    hold = 1'b0;
    wait_strobe("abort_load", 4, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_load strobe_off", dmaport_wr, 0);
    check("abort_load seq_own", seq_own, 0);
    check("abort_load cnt", fifo_cnt, 0);
    repeat (20) @(negedge clk);
    d = mq.pop_front();
    mq.delete();
    compare_desc("abort_load", d, 5);
    check("abort_load extra", log_q.size() - rd_i, 0);
    check("abort_load done_pulses", dd_cnt - dd0, 0);
    check("abort_load busy", busy, 0);

    // Abort during WAIT_DONE with two entries still queued
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = rand_desc();
      model_push(d);
      send_desc(d);
    end
    act_len = 30;
    dd0 = dd_cnt; ci0 = ci_cnt;
    hold = 1'b0;
    wait_strobe("abort_wd", 7, 100);
    repeat (5) @(negedge clk);
    check("abort_wd busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_wd cnt", fifo_cnt, 0);
    wait_idle("abort_wd", 200);
    repeat (20) @(negedge clk);
    d = mq.pop_front();
    mq.delete();
    mq.push_back(d);
    drain_and_compare("abort_wd");
    check("abort_wd done_pulses", dd_cnt - dd0, 1);
    check("abort_wd int_pulses", ci_cnt - ci0, 1);

    // Asynchronous reset during LOAD at k = 5
    act_len = 10;
    d = rand_desc();
    send_desc(d);
    wait_strobe("rst_load", 5, 100);
    #2 reset = 1'b1;
    #1 check("rst_async", {dmaport_wr, dma_zdata, seq_own, busy, fifo_cnt, full, ovf,
                           desc_done, chain_int}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    compare_desc("rst_load", d, 6);
    check("rst_load extra", log_q.size() - rd_i, 0);
    check("rst_load cnt", fifo_cnt, 0);
    check("rst_load busy", busy, 0);
    run_batch("post_rst", 1, 4);

    // Randomized batches: random count (may overflow) and engine latency (0 = timeout path)
    for (int it = 0; it < 8; it++)
      run_batch($sformatf("rand%0d", it), int'($urandom_range(1, 6)), int'($urandom_range(0, 12)));

    check("onehot strobes", onehot_bad, 0);
    check("start after dma_act low", early_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
